// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and word type for the fixed-latency delay pipe (sender and receiver)
package pipe_pkg;
  localparam int PIPE_WIDTH = 3;
  localparam int PIPE_LATENCY = 2;
  localparam int PIPE_RX_DEPTH = 4;
  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;
endpackage

// File: rtl/pipe_rx_fifo.sv
// pipe_rx_fifo: FWFT FIFO; clk, rst (async high), push/wdata in, pop in, rdata head (0 when empty), count out
module pipe_rx_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_RX_DEPTH,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  assign rdata = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/pipe_rx_credit.sv
// pipe_rx_credit: pipe receive terminator; clk, rst, snd_fire/snd_ready credit, rx_valid/rx_data in, out_valid/out_data/out_ready FWFT out, err sticky
module pipe_rx_credit
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_RX_DEPTH,
  parameter int LATENCY = PIPE_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snd_fire,
  output logic             snd_ready,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             err
);
  localparam int CW = $clog2((DEPTH > LATENCY ? DEPTH : LATENCY) + 1);
  localparam logic [CW:0] lim = (CW + 1)'(DEPTH);
  logic [CW-1:0] count, inflight;
  logic pop, push, has_inflight, full, inc, dec;
  always_comb begin
    has_inflight = inflight != '0;
    full = count == lim[CW-1:0];
    pop = out_valid & out_ready;
    push = rx_valid & has_inflight & (~full | pop);
    inc = snd_fire & (inflight != lim[CW-1:0]);
    dec = rx_valid & has_inflight;
    snd_ready = ({1'b0, count} + {1'b0, inflight}) < lim;
    out_valid = count != '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight <= '0;
      err <= 1'b0;
    end else begin
      inflight <= inflight + CW'(inc) - CW'(dec);
      err <= err | (snd_fire & ~snd_ready) | (rx_valid & ~has_inflight) | (rx_valid & has_inflight & full & ~pop);
    end
  pipe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(rx_data),
    .rdata(out_data),
    .count(count)
  );
endmodule

// File: tb/tb_pipe_rx_credit.sv
// tb_pipe_rx_credit: self-checking bench with a delay-pipe model and an output scoreboard
module tb_pipe_rx_credit;
  logic clk = 0;
  logic rst = 1;
  logic snd_fire = 0, snd_ready, rx_valid, out_valid, out_ready = 0, err;
  logic [2:0] snd_data = 0, rx_data, out_data;
  logic inj_v = 0;
  logic [2:0] inj_d = 0;
  logic p1_v = 0, p2_v = 0;
  logic [2:0] p1_d = 0, p2_d = 0;
  logic [2:0] q[$];
  int checks = 0, errors = 0;
  typedef struct {
    logic fire;
    logic [2:0] data;
    logic ordy;
    logic ready;
    logic valid;
  } vec_t;
  vec_t tbl[12];

  pipe_rx_credit dut (
    .clk(clk), .rst(rst), .snd_fire(snd_fire), .snd_ready(snd_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1_v <= snd_fire;
    p1_d <= snd_data;
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign rx_valid = p2_v | inj_v;
  assign rx_data = inj_v ? inj_d : p2_d;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      logic [2:0] e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %0d required none", out_data);
      end else begin
        e = q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data got %0d required %0d", out_data, e);
        end
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic f, input logic [2:0] d, input logic r, input logic inj = 0);
    @(posedge clk);
    #1;
    snd_fire = f;
    snd_data = d;
    out_ready = r;
    inj_v = inj;
    inj_d = d;
    if (f) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    snd_fire = 0;
    inj_v = 0;
    out_ready = 0;
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1, 3'd5, 0, 1, 0};
    tbl[1]  = '{1, 3'd6, 0, 1, 0};
    tbl[2]  = '{1, 3'd7, 0, 1, 0};
    tbl[3]  = '{1, 3'd1, 0, 1, 1};
    tbl[4]  = '{0, 3'd0, 0, 0, 1};
    tbl[5]  = '{0, 3'd0, 0, 0, 1};
    tbl[6]  = '{0, 3'd0, 0, 0, 1};
    tbl[7]  = '{0, 3'd0, 1, 0, 1};
    tbl[8]  = '{0, 3'd0, 1, 1, 1};
    tbl[9]  = '{0, 3'd0, 1, 1, 1};
    tbl[10] = '{0, 3'd0, 1, 1, 1};
    tbl[11] = '{0, 3'd0, 1, 1, 0};

    do_reset();
    chk("idle_snd_ready", snd_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_err", err, 0);
    chk("idle_out_data", out_data, 0);

    for (int c = 0; c < 12; c++) begin
      step(c < 8, 3'(c), 1);
      chk("stream_snd_ready", snd_ready, 1);
      chk("stream_err", err, 0);
      chk("stream_out_valid", out_valid, (c >= 3 && c <= 10) ? 1 : 0);
    end
    chk("stream_drained", q.size(), 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].fire, tbl[i].data, tbl[i].ordy);
      chk("bp_snd_ready", snd_ready, tbl[i].ready);
      chk("bp_out_valid", out_valid, tbl[i].valid);
      chk("bp_err", err, 0);
    end
    chk("bp_drained", q.size(), 0);

    do_reset();
    step(1, 5, 0);
    step(1, 6, 0);
    step(1, 7, 0);
    step(1, 1, 0);
    repeat (3) step(0, 0, 0);
    chk("full_snd_ready", snd_ready, 0);
    chk("full_err_before", err, 0);
    step(1, 3, 0);
    step(0, 0, 0);
    chk("viol_err", err, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("full_pushpop_stays_full", snd_ready, 0);
    repeat (4) step(0, 0, 1);
    chk("full_drained", q.size(), 0);
    chk("full_out_valid_end", out_valid, 0);

    do_reset();
    step(0, 3, 0, 1);
    step(0, 0, 0);
    chk("spur_err", err, 1);
    chk("spur_out_valid", out_valid, 0);
    repeat (3) step(0, 0, 0);
    chk("spur_err_sticky", err, 1);
    chk("spur_out_valid_later", out_valid, 0);

    do_reset();
    step(1, 6, 0);
    repeat (3) step(0, 0, 0);
    chk("pre_async_out_valid", out_valid, 1);
    chk("pre_async_out_data", out_data, 6);
    #1;
    rst = 1;
    q.delete();
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_snd_ready", snd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);

    step(1, 4, 0);
    @(posedge clk);
    #1;
    snd_data = 5;
    rst = 1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    snd_fire = 0;
    @(negedge clk);
    chk("inflight_rst_err_early", err, 0);
    step(0, 0, 1);
    chk("inflight_rst_err", err, 1);
    repeat (2) step(0, 0, 1);
    chk("inflight_rst_err_held", err, 1);
    chk("inflight_rst_dropped", out_valid, 0);

    do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    chk("compliant_err_idle", err, 0);
    step(1, 2, 1);
    repeat (4) step(0, 0, 1);
    chk("compliant_err", err, 0);
    chk("compliant_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
